// File: rtl/router_pkg.sv
// Shared router constants, output-FSM state encoding and the round-robin pick helper.
package router_pkg;

    localparam int NUM_PORTS = 4;
    localparam int PORT_W    = 2;
    localparam int FLIT_W    = 32;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {
        O_IDLE  = 2'd0,
        O_SETUP = 2'd1,
        O_WAIT  = 2'd2
    } out_state_t;

    // Returns {found, index}: the first pending port after 'last', wrapping mod NUM_PORTS.
    // Walking k downwards lets the nearest candidate overwrite farther ones.
    function automatic logic [PORT_W:0] rr_pick(input logic [PORT_W-1:0] last,
                                                input logic [NUM_PORTS-1:0] pend);
        logic [PORT_W:0]   res;
        logic [PORT_W-1:0] idx;
        res = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = last + k[PORT_W-1:0];
            if (pend[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous 2-phase control wire.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/output4to1_arb.sv
// Round-robin 4-to-1 merge of 2-phase bundled-data channels into one clocked,
// FIFO-buffered 2-phase output channel.
module output4to1_arb
    import router_pkg::*;
#(
    parameter int n           = 32,
    parameter int DEPTH       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             in_req,
    output logic [NUM_PORTS-1:0]             in_ack,
    input  logic [NUM_PORTS-1:0][n-1:0]      in_data,
    output logic                             out_req,
    input  logic                             out_ack,
    output logic [n-1:0]                     out_data,
    output logic [PORT_W-1:0]                out_src,
    output logic                             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef struct packed {
        logic [PORT_W-1:0] src;
        logic [n-1:0]      data;
    } entry_t;

    logic [NUM_PORTS-1:0] req_s;
    logic                 ack_s;
    logic [NUM_PORTS-1:0] pend;
    logic [NUM_PORTS-1:0] in_ack_reg;
    logic [PORT_W-1:0]    rr_ptr_reg;
    logic [AW:0]          wr_ptr_reg;
    logic [AW:0]          rd_ptr_reg;
    entry_t               fifo_mem [DEPTH];
    entry_t               head;
    logic                 full;
    logic                 empty;
    logic [PORT_W:0]      pick;
    logic                 grant;
    logic [PORT_W-1:0]    grant_idx;

    out_state_t           state_reg;
    out_state_t           state_next;
    logic                 pop;
    logic                 toggle_req;
    logic                 out_req_reg;
    logic [n-1:0]         out_data_reg;
    logic [PORT_W-1:0]    out_src_reg;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_req_sync
            sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
                .clk (clk),
                .rst (rst),
                .d   (in_req[gi]),
                .q   (req_s[gi])
            );
        end
    endgenerate

    sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (out_ack),
        .q   (ack_s)
    );

    assign pend      = req_s ^ in_ack_reg;
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pick      = rr_pick(rr_ptr_reg, pend);
    assign grant     = pick[PORT_W] && !full;
    assign grant_idx = pick[PORT_W-1:0];
    assign head      = fifo_mem[rd_ptr_reg[AW-1:0]];

    // Arbiter and FIFO pointers; full is evaluated before the edge, so a pop
    // in the same cycle does not enable a grant until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ack_reg <= '0;
            rr_ptr_reg <= PORT_W'(NUM_PORTS - 1);
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (grant) begin
                in_ack_reg[grant_idx] <= ~in_ack_reg[grant_idx];
                rr_ptr_reg            <= grant_idx;
                wr_ptr_reg            <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= '{src: grant_idx, data: in_data[grant_idx]};
        end
    end

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        toggle_req = 1'b0;
        case (state_reg)
            O_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = O_SETUP;
                end
            end
            O_SETUP: begin
                toggle_req = 1'b1;
                state_next = O_WAIT;
            end
            O_WAIT: begin
                if (ack_s == out_req_reg) begin
                    state_next = O_IDLE;
                end
            end
            default: state_next = O_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= O_IDLE;
            out_req_reg  <= 1'b0;
            out_data_reg <= '0;
            out_src_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (pop) begin
                out_data_reg <= head.data;
                out_src_reg  <= head.src;
            end
            if (toggle_req) begin
                out_req_reg <= ~out_req_reg;
            end
        end
    end

    assign in_ack   = in_ack_reg;
    assign out_req  = out_req_reg;
    assign out_data = out_data_reg;
    assign out_src  = out_src_reg;
    assign busy     = !empty || (state_reg != O_IDLE);

endmodule

// File: tb/tb_output4to1_arb.sv
// Scenario bench for output4to1_arb: scoreboard of {src,data} pushed at send, popped at out_req toggles.
module tb_output4to1_arb;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       in_req;
    logic [3:0]       in_ack;
    logic [3:0][31:0] in_data;
    logic             out_req;
    logic             out_ack;
    logic [31:0]      out_data;
    logic [1:0]       out_src;
    logic             busy;

    int total = 0;
    int bad   = 0;
    logic [33:0] sb  [$];
    logic [31:0] sb0 [$];
    logic [31:0] sb3 [$];

    always #5 clk = ~clk;

    output4to1_arb #(.n(32), .DEPTH(2), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_req   (in_req),
        .in_ack   (in_ack),
        .in_data  (in_data),
        .out_req  (out_req),
        .out_ack  (out_ack),
        .out_data (out_data),
        .out_src  (out_src),
        .busy     (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst     = 1'b0;
        in_req  = '0;
        out_ack = 1'b0;
        in_data = '0;
        tick;
        tick;
        rst = 1'b1;
        sb.delete();
        tick;
    endtask

    task automatic test_reset;
        rst     = 1'b0;
        in_req  = '0;
        out_ack = 1'b0;
        in_data = '0;
        tick;
        tick;
        total++;
        if ({in_ack, out_req, out_data, out_src, busy} !== 40'd0) begin
            bad++;
            $display("FAIL reset_values: got ack=%b req=%b data=%h src=%0d busy=%b want all zero",
                     in_ack, out_req, out_data, out_src, busy);
        end
        rst = 1'b1;
        tick;
        tick;
        total++;
        if ({in_ack, out_req, busy} !== 6'd0) begin
            bad++;
            $display("FAIL reset_release_quiet: got ack=%b req=%b busy=%b want 0", in_ack, out_req, busy);
        end
    endtask

    task automatic test_single;
        logic [33:0] exp;
        int c;
        in_data[2] = 32'hA5A5_0001;
        in_req[2]  = ~in_req[2];
        sb.push_back({2'd2, 32'hA5A5_0001});
        tick;
        tick;
        total++;
        if (in_ack[2] !== 1'b0) begin
            bad++;
            $display("FAIL single_early_ack: got in_ack[2]=%b want 0 after edge 1", in_ack[2]);
        end
        tick;
        total++;
        if (in_ack[2] !== 1'b1) begin
            bad++;
            $display("FAIL single_ack_edge2: got in_ack[2]=%b want 1", in_ack[2]);
        end
        tick;
        total++;
        if ({out_req, out_data} !== {1'b0, 32'hA5A5_0001}) begin
            bad++;
            $display("FAIL single_load_edge3: got req=%b data=%h want req=0 data=a5a50001", out_req, out_data);
        end
        tick;
        total++;
        if (out_req !== 1'b1) begin
            bad++;
            $display("FAIL single_req_edge4: got out_req=%b want 1", out_req);
        end
        exp = sb.pop_front();
        total++;
        if ({out_src, out_data} !== exp) begin
            bad++;
            $display("FAIL single_data: got src=%0d data=%h want src=%0d data=%h",
                     out_src, out_data, exp[33:32], exp[31:0]);
        end
        // Second flit must wait for the downstream acknowledge.
        in_data[2] = 32'hA5A5_0002;
        in_req[2]  = ~in_req[2];
        sb.push_back({2'd2, 32'hA5A5_0002});
        for (c = 0; c < 10; c++) tick;
        total++;
        if ({out_req, out_data} !== {1'b1, 32'hA5A5_0001}) begin
            bad++;
            $display("FAIL single_hold_wait: got req=%b data=%h want req=1 data=a5a50001", out_req, out_data);
        end
        out_ack = 1'b1;
        for (c = 0; c < 30 && out_req === 1'b1; c++) tick;
        exp = sb.pop_front();
        total++;
        if ({out_req, out_src, out_data} !== {1'b0, exp}) begin
            bad++;
            $display("FAIL single_second: got req=%b src=%0d data=%h want req=0 src=%0d data=%h",
                     out_req, out_src, out_data, exp[33:32], exp[31:0]);
        end
        out_ack = out_req;
        for (c = 0; c < 30 && busy !== 1'b0; c++) tick;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_all_four;
        logic [33:0] exp;
        logic [3:0]  prev_ack;
        logic [3:0]  exp_bit;
        logic        prev_req;
        int ng, nout, c;
        do_reset;
        for (int i = 0; i < 4; i++) begin
            in_data[i] = 32'hC0DE_0000 + i;
            sb.push_back({i[1:0], 32'hC0DE_0000 + i});
        end
        in_req   = ~in_req;
        prev_ack = in_ack;
        prev_req = out_req;
        ng       = 0;
        nout     = 0;
        for (c = 0; c < 300 && nout < 4; c++) begin
            tick;
            if (in_ack !== prev_ack) begin
                exp_bit = 4'b0001 << ng;
                total++;
                if ((in_ack ^ prev_ack) !== exp_bit) begin
                    bad++;
                    $display("FAIL all4_grant_order: got change=%b want %b", in_ack ^ prev_ack, exp_bit);
                end
                ng++;
                prev_ack = in_ack;
            end
            if (out_req !== prev_req) begin
                exp = (sb.size() != 0) ? sb.pop_front() : 34'h3_FFFF_FFFF;
                total++;
                if ({out_src, out_data} !== exp) begin
                    bad++;
                    $display("FAIL all4_output: got src=%0d data=%h want src=%0d data=%h",
                             out_src, out_data, exp[33:32], exp[31:0]);
                end
                nout++;
                prev_req = out_req;
                out_ack  = out_req;
            end
        end
        total++;
        if (nout != 4 || ng != 4) begin
            bad++;
            $display("FAIL all4_count: got grants=%0d outputs=%0d want 4 and 4", ng, nout);
        end
    endtask

    task automatic test_backpressure;
        logic [33:0] exp;
        logic        prev_req;
        int nout, c;
        prev_req = out_req;
        for (int k = 0; k < 4; k++) begin
            for (c = 0; c < 40 && in_ack[1] !== in_req[1]; c++) tick;
            total++;
            if (in_ack[1] !== in_req[1]) begin
                bad++;
                $display("FAIL bp_accept_%0d: got in_ack[1]=%b want %b", k, in_ack[1], in_req[1]);
            end
            in_data[1] = 32'hB000_0000 + k;
            in_req[1]  = ~in_req[1];
            sb.push_back({2'd1, 32'hB000_0000 + k});
            tick;
        end
        for (c = 0; c < 20; c++) tick;
        total++;
        if (in_ack[1] === in_req[1] || busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_fourth_pending: got in_ack[1]=%b busy=%b want in_ack[1]=%b busy=1",
                     in_ack[1], busy, ~in_req[1]);
        end
        exp = sb.pop_front();
        total++;
        if ({out_req, out_src, out_data} !== {~prev_req, exp}) begin
            bad++;
            $display("FAIL bp_first_out: got req=%b src=%0d data=%h want req=%b src=%0d data=%h",
                     out_req, out_src, out_data, ~prev_req, exp[33:32], exp[31:0]);
        end
        prev_req = out_req;
        out_ack  = out_req;
        nout     = 0;
        for (c = 0; c < 300 && nout < 3; c++) begin
            tick;
            if (out_req !== prev_req) begin
                exp = (sb.size() != 0) ? sb.pop_front() : 34'h3_FFFF_FFFF;
                total++;
                if ({out_src, out_data} !== exp) begin
                    bad++;
                    $display("FAIL bp_output: got src=%0d data=%h want src=%0d data=%h",
                             out_src, out_data, exp[33:32], exp[31:0]);
                end
                nout++;
                prev_req = out_req;
                out_ack  = out_req;
            end
        end
        total++;
        if (nout != 3 || in_ack[1] !== in_req[1]) begin
            bad++;
            $display("FAIL bp_drain: got outputs=%0d in_ack[1]=%b want 3 and %b", nout, in_ack[1], in_req[1]);
        end
    endtask

    task automatic test_fairness;
        logic [3:0]  prev_ack;
        logic [3:0]  exp_bit;
        logic [31:0] exp_data;
        logic        prev_req;
        logic [1:0]  next_grant;
        logic [1:0]  next_out;
        int sent0, sent3, ng, nout, c;
        do_reset;
        sb0.delete();
        sb3.delete();
        prev_ack   = in_ack;
        prev_req   = out_req;
        next_grant = 2'd0;
        next_out   = 2'd0;
        sent0 = 0; sent3 = 0; ng = 0; nout = 0;
        for (c = 0; c < 600 && nout < 8; c++) begin
            if (in_ack[0] === in_req[0] && sent0 < 4) begin
                in_data[0] = 32'hF000_0000 + sent0;
                sb0.push_back(32'hF000_0000 + sent0);
                in_req[0] = ~in_req[0];
                sent0++;
            end
            if (in_ack[3] === in_req[3] && sent3 < 4) begin
                in_data[3] = 32'hF333_0000 + sent3;
                sb3.push_back(32'hF333_0000 + sent3);
                in_req[3] = ~in_req[3];
                sent3++;
            end
            tick;
            if (in_ack !== prev_ack) begin
                exp_bit = (next_grant == 2'd0) ? 4'b0001 : 4'b1000;
                total++;
                if ((in_ack ^ prev_ack) !== exp_bit) begin
                    bad++;
                    $display("FAIL fair_grant_%0d: got change=%b want %b", ng, in_ack ^ prev_ack, exp_bit);
                end
                next_grant = (next_grant == 2'd0) ? 2'd3 : 2'd0;
                ng++;
                prev_ack = in_ack;
            end
            if (out_req !== prev_req) begin
                if (next_out == 2'd0) exp_data = (sb0.size() != 0) ? sb0.pop_front() : 32'hDEAD_BEEF;
                else                  exp_data = (sb3.size() != 0) ? sb3.pop_front() : 32'hDEAD_BEEF;
                total++;
                if ({out_src, out_data} !== {next_out, exp_data}) begin
                    bad++;
                    $display("FAIL fair_output_%0d: got src=%0d data=%h want src=%0d data=%h",
                             nout, out_src, out_data, next_out, exp_data);
                end
                next_out = (next_out == 2'd0) ? 2'd3 : 2'd0;
                nout++;
                prev_req = out_req;
                out_ack  = out_req;
            end
        end
        total++;
        if (nout != 8 || ng != 8) begin
            bad++;
            $display("FAIL fair_count: got grants=%0d outputs=%0d want 8 and 8", ng, nout);
        end
    endtask

    task automatic test_full_pushpop;
        logic [33:0] exp;
        logic [31:0] prev_data;
        logic        prev_req;
        bit          seen_pop, check_next;
        int nout, c;
        do_reset;
        for (int i = 0; i < 4; i++) begin
            in_data[i] = 32'hD000_0000 + i;
            sb.push_back({i[1:0], 32'hD000_0000 + i});
        end
        prev_req = out_req;
        in_req   = ~in_req;
        for (c = 0; c < 25; c++) tick;
        total++;
        if (in_ack !== 4'b0111) begin
            bad++;
            $display("FAIL full_occupancy: got in_ack=%b want 0111", in_ack);
        end
        exp = sb.pop_front();
        total++;
        if ({out_req, out_src, out_data} !== {~prev_req, exp}) begin
            bad++;
            $display("FAIL full_first_out: got req=%b src=%0d data=%h want req=%b src=%0d data=%h",
                     out_req, out_src, out_data, ~prev_req, exp[33:32], exp[31:0]);
        end
        prev_req   = out_req;
        prev_data  = out_data;
        out_ack    = out_req;
        seen_pop   = 0;
        check_next = 0;
        nout       = 0;
        for (c = 0; c < 300 && nout < 3; c++) begin
            tick;
            if (check_next) begin
                total++;
                if (in_ack[3] !== 1'b1) begin
                    bad++;
                    $display("FAIL full_grant_after_pop: got in_ack[3]=%b want 1", in_ack[3]);
                end
                check_next = 0;
            end
            if (!seen_pop && out_data !== prev_data) begin
                total++;
                if (in_ack[3] !== 1'b0) begin
                    bad++;
                    $display("FAIL full_no_grant_on_pop: got in_ack[3]=%b want 0", in_ack[3]);
                end
                seen_pop   = 1;
                check_next = 1;
            end
            if (out_req !== prev_req) begin
                exp = (sb.size() != 0) ? sb.pop_front() : 34'h3_FFFF_FFFF;
                total++;
                if ({out_src, out_data} !== exp) begin
                    bad++;
                    $display("FAIL full_output: got src=%0d data=%h want src=%0d data=%h",
                             out_src, out_data, exp[33:32], exp[31:0]);
                end
                nout++;
                prev_req = out_req;
                out_ack  = out_req;
            end
        end
        total++;
        if (nout != 3 || !seen_pop) begin
            bad++;
            $display("FAIL full_drain: got outputs=%0d pop_seen=%0d want 3 and 1", nout, seen_pop);
        end
    endtask

    task automatic test_reset_mid;
        logic prev_req;
        int c;
        prev_req = out_req;
        for (int i = 0; i < 3; i++) begin
            in_data[i] = 32'hE000_0000 + i;
            in_req[i]  = ~in_req[i];
        end
        for (c = 0; c < 20; c++) tick;
        total++;
        if (out_req === prev_req || busy !== 1'b1 || out_data !== 32'hE000_0000) begin
            bad++;
            $display("FAIL rmid_setup: got req=%b busy=%b data=%h want req=%b busy=1 data=e0000000",
                     out_req, busy, out_data, ~prev_req);
        end
        rst     = 1'b0;
        in_req  = '0;
        out_ack = 1'b0;
        #1;
        total++;
        if ({in_ack, out_req, out_data, out_src, busy} !== 40'd0) begin
            bad++;
            $display("FAIL rmid_async_clear: got ack=%b req=%b data=%h src=%0d busy=%b want all zero",
                     in_ack, out_req, out_data, out_src, busy);
        end
        tick;
        rst = 1'b1;
        sb.delete();
        for (c = 0; c < 20; c++) tick;
        total++;
        if ({in_ack, out_req, busy} !== 6'd0) begin
            bad++;
            $display("FAIL rmid_quiet: got ack=%b req=%b busy=%b want 0", in_ack, out_req, busy);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_all_four;
        test_backpressure;
        test_fairness;
        test_full_pushpop;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
